// File: rtl/hand_centroid.sv
// Accumulates lit-pixel X/Y sums over a raster frame, then serially divides them to get the hand centroid.
// Result strobes a fixed 2*SUM_W+1 cycles after frame_end; frame_end while busy is dropped and flags overrun.
module hand_centroid #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int MIN_PIXELS = 64,
  parameter int SUM_W      = 28,
  parameter int CNT_W      = 19
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pix_valid,
  input  logic       pix_on,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       frame_end,
  output logic [9:0] hand_x,
  output logic [9:0] hand_y,
  output logic       hand_valid,
  output logic       result_strobe,
  output logic       busy,
  output logic       overrun
);

  localparam int STEP_W = $clog2(SUM_W);
  localparam logic [10:0]       X_LIM     = 11'(H_RES);
  localparam logic [10:0]       Y_LIM     = 11'(V_RES);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_PIXELS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, DONE} state_t;
  state_t state, state_nxt;

  logic [SUM_W-1:0]  sum_x, sum_y, sum_x_upd, sum_y_upd, sy, dvd, q_nxt;
  logic [CNT_W-1:0]  cnt, cnt_upd, c, rem, rem_nxt, diff;
  logic [CNT_W:0]    trial;
  logic [STEP_W-1:0] step;
  logic [9:0]        qx;
  logic              qual, ge, step_last, frame_go;

  assign qual      = pix_valid & pix_on & ({1'b0, DrawX} < X_LIM) & ({1'b0, DrawY} < Y_LIM);
  assign sum_x_upd = sum_x + (qual ? {{(SUM_W-10){1'b0}}, DrawX} : '0);
  assign sum_y_upd = sum_y + (qual ? {{(SUM_W-10){1'b0}}, DrawY} : '0);
  assign cnt_upd   = cnt + {{(CNT_W-1){1'b0}}, qual};
  assign frame_go  = frame_end & (state == ACCUM);
  assign step_last = (step == LAST_STEP);

  // Restoring divide step: remainder stays below c, so the modular CNT_W-bit difference is exact when ge.
  assign trial   = {rem, dvd[SUM_W-1]};
  assign ge      = (trial >= {1'b0, c});
  assign diff    = trial[CNT_W-1:0] - c;
  assign rem_nxt = ge ? diff : trial[CNT_W-1:0];
  assign q_nxt   = {dvd[SUM_W-2:0], ge};

  always_ff @(posedge Clk) begin
    if (Reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (frame_end) state_nxt = DIV_X;
      DIV_X:   if (step_last) state_nxt = DIV_Y;
      DIV_Y:   if (step_last) state_nxt = DONE;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sum_x <= '0; sum_y <= '0; cnt <= '0;
      sy <= '0; dvd <= '0; c <= '0; rem <= '0; step <= '0; qx <= '0;
      hand_x <= '0; hand_y <= '0; hand_valid <= 1'b0;
      result_strobe <= 1'b0; busy <= 1'b0; overrun <= 1'b0;
    end else begin
      result_strobe <= 1'b0;
      if (frame_end && state != ACCUM) overrun <= 1'b1;

      if (frame_go) begin
        sum_x <= '0; sum_y <= '0; cnt <= '0;
        dvd   <= sum_x_upd;
        sy    <= sum_y_upd;
        c     <= cnt_upd;
        rem   <= '0;
        step  <= '0;
        busy  <= 1'b1;
      end else begin
        sum_x <= sum_x_upd;
        sum_y <= sum_y_upd;
        cnt   <= cnt_upd;
      end

      if (state == DIV_X || state == DIV_Y) begin
        step <= step_last ? '0 : step + STEP_W'(1);
        dvd  <= q_nxt;
        rem  <= rem_nxt;
      end

      if (state == DIV_X && step_last) begin
        qx  <= q_nxt[9:0];
        dvd <= sy;
        rem <= '0;
      end

      if (state == DIV_Y && step_last) begin
        result_strobe <= 1'b1;
        busy          <= 1'b0;
        if (c >= MIN_C) begin
          hand_x     <= qx;
          hand_y     <= q_nxt[9:0];
          hand_valid <= 1'b1;
        end else begin
          hand_valid <= 1'b0;
        end
      end
    end
  end

endmodule
